// File: rtl/link_energy_pkg.sv
// Shared types and helpers for the link energy monitor: link classes, monitor
// FSM states and the toggle-count width rule.
package link_energy_pkg;

    typedef enum logic [3:0] {
        LC_INVALID     = 4'd0,
        LC_DIM_1       = 4'd1,
        LC_DIM_2       = 4'd2,
        LC_DIM_3       = 4'd3,
        LC_EXPRESS     = 4'd4,
        LC_FORK_FINGER = 4'd5,
        LC_FORK_ARM    = 4'd6
    } link_class_e;

    localparam int ACC_WIDTH_DEFAULT = 64;

    typedef enum logic [1:0] {
        PRIME = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2
    } mon_state_e;

    // Enough bits to hold a count of 0..nbits toggles.
    function automatic int tog_width(input int nbits);
        return $clog2(nbits + 1);
    endfunction

endpackage

// File: rtl/toggle_popcount.sv
// First pipeline stage: remembers the previous sample of all monitored bits and
// registers the number of bits that changed on each capture edge.
module toggle_popcount
    import link_energy_pkg::*;
#(
    parameter int NBITS = 23
) (
    input  logic                         clk,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic                         load_i,
    input  logic                         capture_i,
    input  logic [NBITS-1:0]             cur_i,
    output logic [tog_width(NBITS)-1:0]  tog_o,
    output logic                         valid_o
);

    localparam int TW = tog_width(NBITS);

    logic [NBITS-1:0] prev_q;
    logic [TW-1:0]    tog_q;
    logic [TW-1:0]    pop_d;
    logic             valid_q;

    always_comb begin
        pop_d = '0;
        for (int i = 0; i < NBITS; i++) begin
            pop_d = pop_d + TW'(cur_i[i] ^ prev_q[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q  <= '0;
            tog_q   <= '0;
            valid_q <= 1'b0;
        end else if (clear_i) begin
            prev_q  <= '0;
            tog_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            // valid lasts exactly one edge so each count retires once
            valid_q <= capture_i;
            if (capture_i) begin
                tog_q <= pop_d;
            end
            if (load_i || capture_i) begin
                prev_q <= cur_i;
            end
        end
    end

    assign tog_o   = tog_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/link_energy_monitor.sv
// Per-link toggle energy monitor with saturating lifetime total and windowed total.
// Define LINK_ENERGY_PEAK_EN to add the peak-window register and its report port.
module link_energy_monitor
    import link_energy_pkg::*;
#(
    parameter int NO_CH                   = 1,
    parameter int PHIT_SIZE               = 16,
    parameter int FLOORPLUSONE_LOG2_NO_VC = 4,
    parameter int LINK_ADDR_LENGTH        = 8,
    parameter int LINK_CLASS              = 0,
    parameter int E_PER_TOGGLE            = 5,
    parameter int ACC_WIDTH               = ACC_WIDTH_DEFAULT,
    parameter int WINDOW_LOG2             = 10
) (
    input  logic                                     clk,
    input  logic                                     rs,
    input  logic                                     en,
    input  logic                                     clr,
    input  logic [LINK_ADDR_LENGTH-1:0]              my_addr,
    input  logic [LINK_ADDR_LENGTH-1:0]              report_addr,
    input  logic [NO_CH*PHIT_SIZE-1:0]               data,
    input  logic [NO_CH-1:0]                         sent_req,
    input  logic [NO_CH-1:0]                         new_sig,
    input  logic [NO_CH-1:0]                         ready,
    input  logic [NO_CH*FLOORPLUSONE_LOG2_NO_VC-1:0] vc_no,
    output tri   [ACC_WIDTH-1:0]                     link_energy_consumption,
    output tri   [ACC_WIDTH-1:0]                     link_window_energy,
    output tri   [3:0]                               link_class_out,
    output tri                                       link_energy_sat
`ifdef LINK_ENERGY_PEAK_EN
   ,output tri   [ACC_WIDTH-1:0]                     link_peak_window_energy
`endif
);

    localparam int NBITS = NO_CH * (PHIT_SIZE + 3 + FLOORPLUSONE_LOG2_NO_VC);
    localparam int TW    = tog_width(NBITS);
    localparam link_class_e CLASS_VAL = link_class_e'(4'(LINK_CLASS));

    mon_state_e            state_q, state_d;
    logic [ACC_WIDTH-1:0]  total_q, total_d;
    logic [ACC_WIDTH-1:0]  wacc_q, wacc_d;
    logic [ACC_WIDTH-1:0]  wlast_q, wlast_d;
    logic [WINDOW_LOG2-1:0] wcnt_q, wcnt_d;
    logic                  sat_q, sat_d;
`ifdef LINK_ENERGY_PEAK_EN
    logic [ACC_WIDTH-1:0]  peak_q, peak_d;
`endif

    logic [NBITS-1:0]      cur_bits;
    logic [TW-1:0]         tog;
    logic                  tog_valid;
    logic                  count_en;
    logic                  load_en;
    logic [ACC_WIDTH-1:0]  inc;
    logic [ACC_WIDTH:0]    total_sum;
    logic [ACC_WIDTH-1:0]  win_sum;
    logic                  report_sel;

    assign cur_bits = {data, sent_req, new_sig, ready, vc_no};
    assign count_en = (state_q == RUN) && en && !clr;
    assign load_en  = (state_q == PRIME) && en && !clr;

    toggle_popcount #(.NBITS(NBITS)) u_s1 (
        .clk       (clk),
        .rst_ni    (rs),
        .clear_i   (clr),
        .load_i    (load_en),
        .capture_i (count_en),
        .cur_i     (cur_bits),
        .tog_o     (tog),
        .valid_o   (tog_valid)
    );

    // S2: the count captured on the previous edge is charged now, whatever the state
    assign inc       = tog_valid ? ACC_WIDTH'(tog) * ACC_WIDTH'(E_PER_TOGGLE) : '0;
    assign total_sum = {1'b0, total_q} + {1'b0, inc};
    assign win_sum   = wacc_q + inc;

    always_comb begin
        state_d = state_q;
        total_d = total_q;
        sat_d   = sat_q;
        wacc_d  = win_sum;
        wlast_d = wlast_q;
        wcnt_d  = wcnt_q;
`ifdef LINK_ENERGY_PEAK_EN
        peak_d  = peak_q;
`endif
        unique case (state_q)
            PRIME:   if (en)  state_d = RUN;
            RUN:     if (!en) state_d = HOLD;
            HOLD:    if (en)  state_d = PRIME;
            default: state_d = PRIME;
        endcase

        if (total_sum >= {1'b0, {ACC_WIDTH{1'b1}}}) begin
            total_d = '1;
            sat_d   = 1'b1;
        end else begin
            total_d = total_sum[ACC_WIDTH-1:0];
        end

        if (count_en) begin
            wcnt_d = wcnt_q + 1'b1;
            if (wcnt_q == '1) begin
                wlast_d = win_sum;
                wacc_d  = '0;
`ifdef LINK_ENERGY_PEAK_EN
                if (win_sum > peak_q) peak_d = win_sum;
`endif
            end
        end

        if (clr) begin
            state_d = PRIME;
            total_d = '0;
            sat_d   = 1'b0;
            wacc_d  = '0;
            wlast_d = '0;
            wcnt_d  = '0;
`ifdef LINK_ENERGY_PEAK_EN
            peak_d  = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            state_q <= PRIME;
            total_q <= '0;
            sat_q   <= 1'b0;
            wacc_q  <= '0;
            wlast_q <= '0;
            wcnt_q  <= '0;
`ifdef LINK_ENERGY_PEAK_EN
            peak_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            total_q <= total_d;
            sat_q   <= sat_d;
            wacc_q  <= wacc_d;
            wlast_q <= wlast_d;
            wcnt_q  <= wcnt_d;
`ifdef LINK_ENERGY_PEAK_EN
            peak_q  <= peak_d;
`endif
        end
    end

    // Shared report bus: only the addressed link drives it
    assign report_sel              = (my_addr == report_addr);
    assign link_energy_consumption = report_sel ? total_q   : 'z;
    assign link_window_energy      = report_sel ? wlast_q   : 'z;
    assign link_class_out          = report_sel ? CLASS_VAL : 'z;
    assign link_energy_sat         = report_sel ? sat_q     : 1'bz;
`ifdef LINK_ENERGY_PEAK_EN
    assign link_peak_window_energy = report_sel ? peak_q    : 'z;
`endif

endmodule
